button_command_scheduler: RTL and testbench

// - Shares the game FSM's single command port between NUM_REQ player buttons (P1 up/dn, P2 up/dn).
// - Per button: edge-triggered one-shot request, plus auto-repeat while the button is held.
// - Requests are buffered as sticky pending bits and granted round-robin over a valid/accept handshake.
// - Sits between the input synchronisers and the paddle/game state machine.

---
 rtl/button_command_scheduler_pkg.sv | 16 +
 rtl/button_repeat_channel.sv | 107 ++++++++++
 rtl/button_command_scheduler.sv | 120 ++++++++++++
 tb/tb_button_command_scheduler.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/button_command_scheduler_pkg.sv
// Shared definitions for the button command scheduler.
// - chan_state_e      : per-button channel state encoding
// - REPEAT_*_DEF      : default auto-repeat timing, in Tick strobes
package button_command_scheduler_pkg;

  typedef enum logic [1:0] {
    CH_IDLE    = 2'd0,
    CH_HOLD    = 2'd1,
    CH_REPEAT  = 2'd2,
    CH_BLOCKED = 2'd3
  } chan_state_e;

  localparam int REPEAT_DELAY_DEF  = 50;
  localparam int REPEAT_PERIOD_DEF = 10;

endpackage

// File: rtl/button_repeat_channel.sv
// One button channel: edge-triggered request plus auto-repeat while held.
// Ports:
//   clk    in  system clock
//   reset  in  synchronous active-high reset
//   tick   in  game-rate strobe, advances the hold counter
//   enable in  0 = paused; forces the channel into BLOCKED
//   button in  synchronised button level, 1 = pressed
//   req    out 1-cycle request pulse
//
// state   | meaning
// --------+-------------------------------------------------------------
// IDLE    | waiting for a rising edge on the button
// HOLD    | pressed; counting Ticks towards the first auto-repeat
// REPEAT  | still held; counting Ticks between auto-repeats
// BLOCKED | paused, or held through a pause; waits for enable and release
module button_repeat_channel
  import button_command_scheduler_pkg::*;
#(
  parameter int REPEAT_DELAY  = REPEAT_DELAY_DEF,
  parameter int REPEAT_PERIOD = REPEAT_PERIOD_DEF,
  parameter int CNT_W         = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic tick,
  input  logic enable,
  input  logic button,
  output logic req
);

  localparam logic [CNT_W-1:0] DELAY_C  = CNT_W'(REPEAT_DELAY);
  localparam logic [CNT_W-1:0] PERIOD_C = CNT_W'(REPEAT_PERIOD);

  chan_state_e      state_q, state_d;
  logic             prev_q, prev_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] cnt_inc;

  assign cnt_inc = cnt_q + 1'b1;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    prev_d  = button;
    req     = 1'b0;
    if (!enable) begin
      state_d = CH_BLOCKED;
      cnt_d   = '0;
    end else begin
      case (state_q)
        CH_IDLE: begin
          if (button && !prev_q) begin
            req     = 1'b1;
            state_d = CH_HOLD;
            cnt_d   = '0;
          end
        end
        CH_HOLD: begin
          // release wins over a Tick in the same cycle
          if (!button) begin
            state_d = CH_IDLE;
            cnt_d   = '0;
          end else if (tick) begin
            if (cnt_inc == DELAY_C) begin
              req     = 1'b1;
              cnt_d   = '0;
              state_d = CH_REPEAT;
            end else begin
              cnt_d = cnt_inc;
            end
          end
        end
        CH_REPEAT: begin
          if (!button) begin
            state_d = CH_IDLE;
            cnt_d   = '0;
          end else if (tick) begin
            if (cnt_inc == PERIOD_C) begin
              req   = 1'b1;
              cnt_d = '0;
            end else begin
              cnt_d = cnt_inc;
            end
          end
        end
        CH_BLOCKED: begin
          // a button held through a pause must be released before it can fire
          if (!button) state_d = CH_IDLE;
        end
        default: state_d = CH_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= CH_IDLE;
      prev_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      prev_q  <= prev_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: rtl/button_command_scheduler.sv
// Shares one command port between NUM_REQ player buttons.
// Ports:
//   CLOCK, Reset     system clock, synchronous active-high reset
//   Tick             game-rate strobe for the repeat timers
//   Enable           0 = paused; clears Pending and drops CmdValid
//   ButtonIn         synchronised button levels
//   CmdAccept        game FSM consumes the presented command
//   CmdValid, CmdId  registered command handshake
//   Pending          sticky per-button request bits
//   Overrun          1-cycle pulse when a request hits a pending bit
module button_command_scheduler
  import button_command_scheduler_pkg::*;
#(
  parameter int NUM_REQ       = 4,
  parameter int ID_W          = 2,
  parameter int REPEAT_DELAY  = REPEAT_DELAY_DEF,
  parameter int REPEAT_PERIOD = REPEAT_PERIOD_DEF,
  parameter int CNT_W         = 8
) (
  input  logic               CLOCK,
  input  logic               Reset,
  input  logic               Tick,
  input  logic               Enable,
  input  logic [NUM_REQ-1:0] ButtonIn,
  input  logic               CmdAccept,
  output logic               CmdValid,
  output logic [ID_W-1:0]    CmdId,
  output logic [NUM_REQ-1:0] Pending,
  output logic               Overrun
);

  logic [NUM_REQ-1:0] req;

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_chan
    button_repeat_channel #(
      .REPEAT_DELAY (REPEAT_DELAY),
      .REPEAT_PERIOD(REPEAT_PERIOD),
      .CNT_W        (CNT_W)
    ) u_chan (
      .clk   (CLOCK),
      .reset (Reset),
      .tick  (Tick),
      .enable(Enable),
      .button(ButtonIn[g]),
      .req   (req[g])
    );
  end

  logic [NUM_REQ-1:0] pending_q, pending_d;
  logic               valid_q, valid_d;
  logic [ID_W-1:0]    id_q, id_d;
  logic [ID_W-1:0]    ptr_q, ptr_d;
  logic               overrun_q, overrun_d;

  logic [NUM_REQ-1:0] clr_mask;
  logic               grant_found;
  logic [ID_W-1:0]    grant_idx;
  logic [ID_W-1:0]    cand;

  always_comb begin
    clr_mask = '0;
    if (valid_q && CmdAccept) clr_mask[id_q] = 1'b1;

    // round-robin: first pending bit strictly after the last grant
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = ID_W'((int'(ptr_q) + k) % NUM_REQ);
      if (!grant_found && pending_q[cand]) begin
        grant_found = 1'b1;
        grant_idx   = cand;
      end
    end

    pending_d = pending_q;
    valid_d   = valid_q;
    id_d      = id_q;
    ptr_d     = ptr_q;
    overrun_d = 1'b0;

    if (!Enable) begin
      pending_d = '0;
      valid_d   = 1'b0;
    end else begin
      // a request landing on the bit being accepted re-arms it without overrun
      pending_d = (pending_q & ~clr_mask) | req;
      overrun_d = |(req & pending_q & ~clr_mask);
      if (valid_q) begin
        if (CmdAccept) valid_d = 1'b0;
      end else if (grant_found) begin
        valid_d = 1'b1;
        id_d    = grant_idx;
        ptr_d   = grant_idx;
      end
    end
  end

  always_ff @(posedge CLOCK) begin
    if (Reset) begin
      pending_q <= '0;
      valid_q   <= 1'b0;
      id_q      <= '0;
      ptr_q     <= ID_W'(NUM_REQ - 1);
      overrun_q <= 1'b0;
    end else begin
      pending_q <= pending_d;
      valid_q   <= valid_d;
      id_q      <= id_d;
      ptr_q     <= ptr_d;
      overrun_q <= overrun_d;
    end
  end

  assign CmdValid = valid_q;
  assign CmdId    = id_q;
  assign Pending  = pending_q;
  assign Overrun  = overrun_q;

endmodule

// File: tb/tb_button_command_scheduler.sv
module tb_button_command_scheduler;

  localparam int N = 4;
  localparam int D = 50;
  localparam int P = 10;

  logic         CLOCK = 1'b0;
  logic         Reset, Tick, Enable, CmdAccept;
  logic [N-1:0] ButtonIn;
  logic         CmdValid;
  logic [1:0]   CmdId;
  logic [N-1:0] Pending;
  logic         Overrun;

  button_command_scheduler dut (
    .CLOCK    (CLOCK),
    .Reset    (Reset),
    .Tick     (Tick),
    .Enable   (Enable),
    .ButtonIn (ButtonIn),
    .CmdAccept(CmdAccept),
    .CmdValid (CmdValid),
    .CmdId    (CmdId),
    .Pending  (Pending),
    .Overrun  (Overrun)
  );

  always #5 CLOCK = ~CLOCK;

  typedef struct packed {
    logic         v;
    logic [1:0]   id;
    logic [N-1:0] p;
    logic         o;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   rises = 0;

  // reference model: per-button "armed / blocked / ticks held" bookkeeping
  int       m_ticks[N];
  bit       m_armed[N];
  bit       m_blk[N];
  bit       m_prev[N];
  bit       m_valid;
  int       m_id;
  int       m_ptr;
  bit [N-1:0] m_pend;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step(input bit r, input bit en, input bit tk,
                            input bit [N-1:0] b, input bit acc);
    bit [N-1:0] reqs, clr, pend_n;
    bit         ovr_n, valid_n;
    int         id_n, ptr_n, c;
    exp_t       e;
    reqs = '0;
    if (r) begin
      for (int i = 0; i < N; i++) begin
        m_ticks[i] = 0; m_armed[i] = 0; m_blk[i] = 0; m_prev[i] = 0;
      end
      m_valid = 0; m_id = 0; m_ptr = N - 1; m_pend = '0;
      ovr_n = 0;
    end else begin
      for (int i = 0; i < N; i++) begin
        if (!en) begin
          m_blk[i] = 1; m_armed[i] = 0;
        end else if (m_blk[i]) begin
          if (!b[i]) m_blk[i] = 0;
        end else if (m_armed[i]) begin
          if (!b[i]) m_armed[i] = 0;
          else if (tk) begin
            m_ticks[i]++;
            if (m_ticks[i] == D || (m_ticks[i] > D && (m_ticks[i] - D) % P == 0))
              reqs[i] = 1;
          end
        end else if (b[i] && !m_prev[i]) begin
          reqs[i] = 1; m_armed[i] = 1; m_ticks[i] = 0;
        end
        m_prev[i] = b[i];
      end
      clr = '0;
      if (m_valid && acc) clr[m_id] = 1;
      ovr_n   = en && ((reqs & m_pend & ~clr) != 0);
      pend_n  = en ? ((m_pend & ~clr) | reqs) : '0;
      valid_n = m_valid;
      id_n    = m_id;
      ptr_n   = m_ptr;
      if (!en) valid_n = 0;
      else if (m_valid) valid_n = !acc;
      else if (m_pend != 0) begin
        for (int k = 1; k <= N; k++) begin
          c = (m_ptr + k) % N;
          if (!valid_n && m_pend[c]) begin
            valid_n = 1; id_n = c; ptr_n = c;
          end
        end
      end
      m_valid = valid_n; m_id = id_n; m_ptr = ptr_n; m_pend = pend_n;
    end
    e.v = m_valid; e.id = 2'(m_id); e.p = m_pend; e.o = ovr_n;
    exp_q.push_back(e);
  endtask

  task automatic cyc(input bit r, input bit en, input bit tk,
                     input bit [N-1:0] b, input bit acc);
    @(negedge CLOCK);
    Reset = r; Enable = en; Tick = tk; ButtonIn = b; CmdAccept = acc;
    model_step(r, en, tk, b, acc);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 1, 0, '0, 0);
  endtask

  // monitor: compares every registered output against the queued expectation
  initial begin
    exp_t e;
    bit   pv;
    pv = 0;
    forever begin
      @(posedge CLOCK);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("CmdValid", int'(CmdValid), int'(e.v));
        check("CmdId",    int'(CmdId),    int'(e.id));
        check("Pending",  int'(Pending),  int'(e.p));
        check("Overrun",  int'(Overrun),  int'(e.o));
      end
      if (CmdValid === 1'b1 && !pv) rises++;
      pv = (CmdValid === 1'b1);
    end
  end

  initial begin
    int base, hold_ticks, exp_cmds;
    bit [N-1:0] btn;
    Reset = 1; Enable = 1; Tick = 0; ButtonIn = '0; CmdAccept = 0;

    repeat (3) cyc(1, 1, 0, '0, 0);
    idle(2);

    // single press on button 2, accept when presented
    base = rises;
    cyc(0, 1, 0, 4'b0100, 0);
    cyc(0, 1, 0, 4'b0100, 0);
    cyc(0, 1, 0, 4'b0100, 1);
    idle(4);
    check("single_press_cmds", rises - base, 1);

    // auto-repeat on button 0, Tick every 4 cycles
    base = rises;
    hold_ticks = 85;
    for (int c = 0; c < hold_ticks * 4 + 2; c++)
      cyc(0, 1, (c % 4 == 0) && (c > 0), 4'b0001, 1);
    for (int c = 0; c < 40; c++) cyc(0, 1, (c % 4 == 0), '0, 1);
    exp_cmds = 1 + ((hold_ticks >= D) ? 1 + (hold_ticks - D) / P : 0);
    check("auto_repeat_cmds", rises - base, exp_cmds);

    // round-robin, twice
    base = rises;
    repeat (10) cyc(0, 1, 0, 4'b1111, 1);
    cyc(0, 1, 0, '0, 1);
    repeat (10) cyc(0, 1, 0, 4'b1111, 1);
    idle(3);
    check("round_robin_cmds", rises - base, 2 * N);

    // stall then overrun on button 1
    repeat (4) cyc(0, 1, 0, 4'b0010, 0);
    cyc(0, 1, 0, '0, 0);
    repeat (3) cyc(0, 1, 0, 4'b0010, 0);
    cyc(0, 1, 0, 4'b0010, 1);
    repeat (3) cyc(0, 1, 0, 4'b0010, 0);
    idle(2);

    // pause with button 3 held through it
    repeat (4) cyc(0, 1, 0, 4'b1000, 0);
    repeat (3) cyc(0, 0, 1, 4'b1000, 1);
    base = rises;
    repeat (6) cyc(0, 1, 1, 4'b1000, 1);
    check("held_through_pause_cmds", rises - base, 0);
    cyc(0, 1, 0, '0, 0);
    repeat (3) cyc(0, 1, 0, 4'b1000, 0);
    cyc(0, 1, 0, 4'b1000, 1);
    idle(3);
    check("after_pause_cmds", rises - base, 1);

    // reset mid-handshake, then a fresh contest
    repeat (4) cyc(0, 1, 0, 4'b0110, 0);
    cyc(1, 1, 0, '0, 0);
    repeat (3) cyc(0, 1, 0, 4'b1111, 1);
    idle(8);

    // randomized traffic: frequent pauses, then long holds with fast Ticks
    btn = '0;
    for (int c = 0; c < 4000; c++) begin
      bit r, en, tk;
      r  = ($urandom_range(0, 999) == 0);
      en = (c < 2000) ? ($urandom_range(0, 39) != 0) : ($urandom_range(0, 399) != 0);
      tk = (c < 2000) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 3) != 0);
      for (int i = 0; i < N; i++)
        if ($urandom_range(0, (c < 2000) ? 29 : 199) == 0) btn[i] = ~btn[i];
      cyc(r, en, tk, btn, bit'($urandom_range(0, 1)));
    end
    idle(4);

    @(posedge CLOCK);
    #2;
    check("scoreboard_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
